// File: rtl/sal_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sal_fifo_pkg
//   Shared types and helpers for the multi-channel request FIFO (sal_mc_fifo)
//   and its per-channel controller (sal_fifo_ctrl).
//   - fifo_status_t : per-channel status flags {full, afull, empty, aempty}
//   - clog2_min1()  : $clog2 that never returns less than 1, for index widths
// ---------------------------------------------------------------------------
package sal_fifo_pkg;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } fifo_status_t;

  // A single-channel build still needs a 1-bit channel select port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sal_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sal_fifo_ctrl
//   Pointer, occupancy and flag bookkeeping for one channel of sal_mc_fifo.
//   Storage lives in the parent; this block only decides acceptance and
//   supplies the slot addresses.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   wr_req, rd_req    write / read requested on this channel this cycle
//   wr_ok, rd_ok      request accepted (combinational from registered flags)
//   wr_addr, rd_addr  slot within this channel's partition
//   cnt               registered occupancy, 0..2**DEPTH_LG2
//   status            registered {full, afull, empty, aempty}
//   ovf, udf          sticky rejected-write / rejected-read flags
// ---------------------------------------------------------------------------
module sal_fifo_ctrl
  import sal_fifo_pkg::*;
#(
  parameter int DEPTH_LG2    = 3,
  parameter int AFULL_THRES  = (1 << DEPTH_LG2) - 1,
  parameter int AEMPTY_THRES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic                 rd_req,
  output logic                 wr_ok,
  output logic                 rd_ok,
  output logic [DEPTH_LG2-1:0] wr_addr,
  output logic [DEPTH_LG2-1:0] rd_addr,
  output logic [DEPTH_LG2:0]   cnt,
  output fifo_status_t         status,
  output logic                 ovf,
  output logic                 udf
);

  localparam int PTR_W = DEPTH_LG2 + 1;
  localparam logic [PTR_W-1:0] AFULL_CNT  = PTR_W'(AFULL_THRES);
  localparam logic [PTR_W-1:0] AEMPTY_CNT = PTR_W'(AEMPTY_THRES);

  logic [PTR_W-1:0] wrptr_q, rdptr_q, wrptr_d, rdptr_d;
  logic [PTR_W-1:0] cnt_q, cnt_d;
  fifo_status_t     status_q, status_d;
  logic             ovf_q, udf_q;

  // Acceptance looks only at registered flags, so a full channel rejects a
  // same-cycle write even when a read frees a slot, and an empty channel
  // rejects a same-cycle read even when a write arrives (no bypass).
  assign wr_ok = wr_req & ~status_q.full;
  assign rd_ok = rd_req & ~status_q.empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wrptr_d         = wrptr_q + PTR_W'(wr_ok);
    rdptr_d         = rdptr_q + PTR_W'(rd_ok);
    cnt_d           = wrptr_d - rdptr_d;
    status_d        = '0;
    status_d.full   = (wrptr_d[PTR_W-1] != rdptr_d[PTR_W-1]) &&
                      (wrptr_d[PTR_W-2:0] == rdptr_d[PTR_W-2:0]);
    status_d.empty  = (wrptr_d == rdptr_d);
    status_d.afull  = (cnt_d >= AFULL_CNT);
    status_d.aempty = (cnt_d <= AEMPTY_CNT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      cnt_q    <= '0;
      status_q <= '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wrptr_q  <= wrptr_d;
      rdptr_q  <= rdptr_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      ovf_q    <= ovf_q | (wr_req & status_q.full);
      udf_q    <= udf_q | (rd_req & status_q.empty);
    end
  end

  assign wr_addr = wrptr_q[DEPTH_LG2-1:0];
  assign rd_addr = rdptr_q[DEPTH_LG2-1:0];
  assign cnt     = cnt_q;
  assign status  = status_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule

// File: rtl/sal_mc_fifo.sv
// ---------------------------------------------------------------------------
// sal_mc_fifo
//   NUM_CH independent FIFOs sharing one statically partitioned storage array,
//   one write port and one read port, each steered by a channel index.
//   Buffers per-bank requests between the DDR2 scheduler and the command path.
//   Channel c owns slots c*DEPTH .. c*DEPTH+DEPTH-1.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   wren_i/wch_i/wdata_i  write request, channel, payload
//   rden_i/rch_i          read request, channel
//   rvalid_o/rdata_o      registered read data, valid 1 cycle after accept;
//                         rdata_o holds its last value otherwise
//   rperr_o               parity error on rdata_o, qualified by rvalid_o
//   full_o/afull_o/empty_o/aempty_o  per-channel registered flags
//   cnt_o                 per-channel occupancy, DEPTH_LG2+1 bits each
//   ovf_o/udf_o           per-channel sticky rejected write / read
//
// Build option
//   SAL_MCFIFO_PARITY_EN  store an even-parity bit with each word and check it
//                         on read; when undefined rperr_o is tied low.
// ---------------------------------------------------------------------------
module sal_mc_fifo
  import sal_fifo_pkg::*;
#(
  parameter int  NUM_CH       = 4,
  parameter int  DEPTH_LG2    = 3,
  parameter int  DATA_WIDTH   = 32,
  parameter int  AFULL_THRES  = (1 << DEPTH_LG2) - 1,
  parameter int  AEMPTY_THRES = 1,
  localparam int CH_W         = clog2_min1(NUM_CH),
  localparam int CNT_W        = DEPTH_LG2 + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wren_i,
  input  logic [CH_W-1:0]         wch_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    rden_i,
  input  logic [CH_W-1:0]         rch_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rperr_o,
  output logic [NUM_CH-1:0]       full_o,
  output logic [NUM_CH-1:0]       afull_o,
  output logic [NUM_CH-1:0]       empty_o,
  output logic [NUM_CH-1:0]       aempty_o,
  output logic [NUM_CH*CNT_W-1:0] cnt_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic [NUM_CH-1:0]       udf_o
);

  localparam int ADDR_W = CH_W + DEPTH_LG2;
`ifdef SAL_MCFIFO_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  logic [NUM_CH-1:0]    wr_req, rd_req, wr_ok, rd_ok;
  logic [DEPTH_LG2-1:0] wr_addr [NUM_CH];
  logic [DEPTH_LG2-1:0] rd_addr [NUM_CH];
  fifo_status_t         status  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // A channel index beyond NUM_CH matches no controller, so it is ignored.
    assign wr_req[c] = wren_i && (wch_i == CH_W'(c));
    assign rd_req[c] = rden_i && (rch_i == CH_W'(c));

    sal_fifo_ctrl #(
      .DEPTH_LG2   (DEPTH_LG2),
      .AFULL_THRES (AFULL_THRES),
      .AEMPTY_THRES(AEMPTY_THRES)
    ) u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_req (wr_req[c]),
      .rd_req (rd_req[c]),
      .wr_ok  (wr_ok[c]),
      .rd_ok  (rd_ok[c]),
      .wr_addr(wr_addr[c]),
      .rd_addr(rd_addr[c]),
      .cnt    (cnt_o[c*CNT_W +: CNT_W]),
      .status (status[c]),
      .ovf    (ovf_o[c]),
      .udf    (udf_o[c])
    );

    assign full_o[c]   = status[c].full;
    assign afull_o[c]  = status[c].afull;
    assign empty_o[c]  = status[c].empty;
    assign aempty_o[c] = status[c].aempty;
  end

  // {channel, slot} is exactly channel*DEPTH + slot.
  logic [ADDR_W-1:0] waddr, raddr;
  always_comb begin
    waddr = '0;
    raddr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ok[c]) waddr = {CH_W'(c), wr_addr[c]};
      if (rd_ok[c]) raddr = {CH_W'(c), rd_addr[c]};
    end
  end

  logic [MEM_W-1:0] wword, rword;
`ifdef SAL_MCFIFO_PARITY_EN
  assign wword = {^wdata_i, wdata_i};
`else
  assign wword = wdata_i;
`endif

  logic [MEM_W-1:0] mem [1 << ADDR_W];

  // NOTE: storage is deliberately left out of reset; pointers guarantee no
  // slot is read before it is written, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (|wr_ok) mem[waddr] <= wword;
  end

  assign rword = mem[raddr];

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= |rd_ok;
      if (|rd_ok) rdata_q <= rword[DATA_WIDTH-1:0];
    end
  end

`ifdef SAL_MCFIFO_PARITY_EN
  logic rperr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) rperr_q <= 1'b0;
    else        rperr_q <= (|rd_ok) && (rword[DATA_WIDTH] != ^rword[DATA_WIDTH-1:0]);
  end
  assign rperr_o = rperr_q;
`else
  assign rperr_o = 1'b0;
`endif

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule
